// File: rtl/video_timing_ctrl_pkg.sv
// Shared types and timing constant sets for the video raster sequencer.
// Holds the 720p defaults and a tiny raster used for fast simulation.
package video_timing_ctrl_pkg;

  typedef logic [15:0] rgb565_t;
  typedef logic [11:0] coord_t;

  localparam int HD_H_SYNC  = 40;
  localparam int HD_H_BACK  = 220;
  localparam int HD_H_DISP  = 1280;
  localparam int HD_H_FRONT = 110;
  localparam int HD_V_SYNC  = 5;
  localparam int HD_V_BACK  = 20;
  localparam int HD_V_DISP  = 720;
  localparam int HD_V_FRONT = 5;

  localparam int SIM_H_SYNC  = 2;
  localparam int SIM_H_BACK  = 2;
  localparam int SIM_H_DISP  = 8;
  localparam int SIM_H_FRONT = 2;
  localparam int SIM_V_SYNC  = 1;
  localparam int SIM_V_BACK  = 1;
  localparam int SIM_V_DISP  = 4;
  localparam int SIM_V_FRONT = 1;

  // Sync pins sit at the inactive level whenever timing is stopped.
  function automatic logic sync_level(input logic raw, input logic run, input logic pol);
    return (run & raw) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_raster_counter.sv
// Wrap counter for one raster axis: advances on carry-in, wraps at TOTAL-1
// and signals the wrap on carry-out; a clear forces it back to zero.
module raster_counter
  import video_timing_ctrl_pkg::*;
#(
  parameter int TOTAL = 1650
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   cin,
  output coord_t cnt,
  output logic   cout
);

  coord_t cnt_q;
  coord_t cnt_d;

  assign cout = cin & (cnt_q == coord_t'(TOTAL - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cout) begin
      cnt_d = '0;
    end else if (cin) begin
      cnt_d = cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Video raster sequencer: counters, syncs, data-enable and registered pixel path.
// Optional VIDEO_FRAME_CNT_EN adds a 16-bit frame counter output.
module video_timing_ctrl
  import video_timing_ctrl_pkg::*;
#(
  parameter int   H_SYNC   = HD_H_SYNC,
  parameter int   H_BACK   = HD_H_BACK,
  parameter int   H_DISP   = HD_H_DISP,
  parameter int   H_FRONT  = HD_H_FRONT,
  parameter int   V_SYNC   = HD_V_SYNC,
  parameter int   V_BACK   = HD_V_BACK,
  parameter int   V_DISP   = HD_V_DISP,
  parameter int   V_FRONT  = HD_V_FRONT,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        en,
  input  rgb565_t     rd_data,
  output coord_t      pixel_xpos,
  output coord_t      pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output rgb565_t     video_rgb,
`ifdef VIDEO_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
  localparam coord_t H_ACT_LO   = coord_t'(H_SYNC + H_BACK);
  localparam coord_t H_ACT_HI   = coord_t'(H_SYNC + H_BACK + H_DISP);
  localparam coord_t V_SYNC_END = coord_t'(V_SYNC);
  localparam coord_t V_ACT_LO   = coord_t'(V_SYNC + V_BACK);
  localparam coord_t V_ACT_HI   = coord_t'(V_SYNC + V_BACK + V_DISP);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap;

  // Stopping timing clears both axes so a restart always begins a fresh frame.
  raster_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk  (pixel_clk),
    .rst  (rst),
    .clr  (~en),
    .cin  (en),
    .cnt  (h_cnt),
    .cout (h_wrap)
  );

  raster_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk  (pixel_clk),
    .rst  (rst),
    .clr  (~en),
    .cin  (h_wrap),
    .cnt  (v_cnt),
    .cout (v_wrap)
  );

  logic hs_raw;
  logic vs_raw;
  logic h_act;
  logic v_act;

  assign hs_raw     = h_cnt < H_SYNC_END;
  assign vs_raw     = v_cnt < V_SYNC_END;
  assign h_act      = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
  assign v_act      = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
  assign data_req   = h_act & v_act & en;
  assign pixel_xpos = data_req ? (h_cnt - H_ACT_LO) : '0;
  assign pixel_ypos = data_req ? (v_cnt - V_ACT_LO) : '0;

  // Output register stage: everything below lands one cycle after the counters.
  logic    hs_q, hs_d;
  logic    vs_q, vs_d;
  logic    de_q, de_d;
  rgb565_t rgb_q, rgb_d;
  logic    fs_q, fs_d;

  always_comb begin
    hs_d  = sync_level(hs_raw, en, SYNC_POL);
    vs_d  = sync_level(vs_raw, en, SYNC_POL);
    de_d  = data_req;
    rgb_d = data_req ? rd_data : '0;
    fs_d  = en & (h_cnt == '0) & (v_cnt == '0);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
    end
  end

  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = fs_q;

`ifdef VIDEO_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  // Updates on the same edge that raises frame_start, so both agree.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      frame_cnt_d = '0;
    end else if (fs_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on the small simulation raster, against a
// position-in-frame reference model with randomised enable and pixel data.
module tb_video_timing_ctrl;
  import video_timing_ctrl_pkg::*;

  localparam int HT = SIM_H_SYNC + SIM_H_BACK + SIM_H_DISP + SIM_H_FRONT;
  localparam int VT = SIM_V_SYNC + SIM_V_BACK + SIM_V_DISP + SIM_V_FRONT;
  localparam int FRAME = HT * VT;
  localparam int HA0 = SIM_H_SYNC + SIM_H_BACK;
  localparam int VA0 = SIM_V_SYNC + SIM_V_BACK;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] rnd_val;
  rgb565_t     rd_data;
  coord_t      pixel_xpos, pixel_ypos;
  logic        data_req, video_hs, video_vs, video_de, frame_start;
  rgb565_t     video_rgb;
`ifdef VIDEO_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 pixel_clk = ~pixel_clk;

  assign rd_data = (mode == 2'd0) ? {pixel_ypos[3:0], pixel_xpos} :
                   (mode == 2'd1) ? 16'hFFFF : rnd_val;

  video_timing_ctrl #(
    .H_SYNC(SIM_H_SYNC), .H_BACK(SIM_H_BACK), .H_DISP(SIM_H_DISP), .H_FRONT(SIM_H_FRONT),
    .V_SYNC(SIM_V_SYNC), .V_BACK(SIM_V_BACK), .V_DISP(SIM_V_DISP), .V_FRONT(SIM_V_FRONT),
    .SYNC_POL(1'b1)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .en          (en),
    .rd_data     (rd_data),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .data_req    (data_req),
    .video_hs    (video_hs),
    .video_vs    (video_vs),
    .video_de    (video_de),
    .video_rgb   (video_rgb),
`ifdef VIDEO_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .frame_start (frame_start)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: position within the frame since counting (re)started.
  int          pos;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [15:0] e_rgb;
  logic [15:0] e_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_rgb = '0; e_fs = 1'b0; e_fc = '0;
  endtask

  task automatic check_regs();
    chk("video_hs", video_hs, e_hs);
    chk("video_vs", video_vs, e_vs);
    chk("video_de", video_de, e_de);
    chk("video_rgb", video_rgb, e_rgb);
    chk("frame_start", frame_start, e_fs);
`ifdef VIDEO_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, e_fc);
`endif
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances model at posedge.
  task automatic cycle(input logic en_i, input logic [1:0] mode_i);
    int h, v;
    logic req;
    logic [11:0] ex, ey;
    logic [15:0] rd;
    en = en_i; mode = mode_i; rnd_val = 16'($urandom);
    @(negedge pixel_clk);
    check_regs();
    h = pos % HT;
    v = pos / HT;
    req = !rst && en && (h >= HA0) && (h < HA0 + SIM_H_DISP) && (v >= VA0) && (v < VA0 + SIM_V_DISP);
    ex = req ? 12'(h - HA0) : 12'd0;
    ey = req ? 12'(v - VA0) : 12'd0;
    chk("data_req", data_req, req);
    chk("pixel_xpos", pixel_xpos, ex);
    chk("pixel_ypos", pixel_ypos, ey);
    rd = (mode == 2'd0) ? {ey[3:0], ex} : (mode == 2'd1) ? 16'hFFFF : rnd_val;
    if (rst) begin
      model_reset();
    end else begin
      e_hs  = en && (h < SIM_H_SYNC);
      e_vs  = en && (v < SIM_V_SYNC);
      e_de  = req;
      e_rgb = req ? rd : 16'h0000;
      e_fs  = en && (pos == 0);
      e_fc  = !en ? 16'h0 : (pos == 0) ? e_fc + 16'd1 : e_fc;
      pos   = en ? (pos + 1) % FRAME : 0;
    end
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; rnd_val = '0;
    model_reset();
    #2;
    check_regs();
    chk("reset_data_req", data_req, 1'b0);
    @(posedge pixel_clk); #1;
    cycle(1'b0, 2'd0);
    rst = 1'b0;

    // Two full frames of coordinate-derived pixel data after reset release.
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 2'd0);
    // Saturated source: blanking must still force rgb to zero.
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 2'd1);

    // Drop enable at h=6, v=3, then restart.
    for (int i = 0; i < 2 * FRAME && pos != 3 * HT + 6; i++) cycle(1'b1, 2'd0);
    chk("reach_h6_v3", pos, 3 * HT + 6);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0);
    for (int i = 0; i < FRAME + 5; i++) cycle(1'b1, 2'd2);

    // Randomised enable and source data.
    for (int i = 0; i < 800; i++)
      cycle(($urandom % 60) != 0, 2'($urandom % 3));

    // Asynchronous reset mid-line with no clock edge in between.
    for (int i = 0; i < 2 * FRAME && (pos % HT) != HA0 + 3; i++) cycle(1'b1, 2'd0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("async_rst_data_req", data_req, 1'b0);
    chk("async_rst_xpos", pixel_xpos, 12'd0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 3 * FRAME; i++) cycle(1'b1, 2'd0);
`ifdef VIDEO_FRAME_CNT_EN
    chk("frame_cnt_after_3", frame_cnt, 16'd3);
`endif
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
